bit_demux_collector: RTL and testbench

- Inverse of the CPU's mux-tree bit selector.
- Accepts single bits, each tagged with a select index, and writes each bit into that position of a DATA_WIDTH word.
- Once every position has been written, presents the assembled word on a valid/ready output.
- Used to rebuild words that were serialized bit-by-bit by the selector mux tree (e.g. debug or bit-serial datapath return path).

---
 rtl/bit_demux_collector_pkg.sv | 18 +
 rtl/bit_demux_1xn.sv | 32 +++
 rtl/bit_demux_collector.sv | 101 ++++++++++
 tb/tb_bit_demux_collector.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/bit_demux_collector_pkg.sv
// Shared types and constants for the bit demux collector.
//   state_e            : collector FSM states (COLLECT, FULL)
//   DEFAULT_SEL_WIDTH  : default number of select bits / demux tree levels
//   mask_width()       : width of the fill mask (and of its ALL_ONES value)
package bit_demux_collector_pkg;

  typedef enum logic {
    COLLECT = 1'b0,
    FULL    = 1'b1
  } state_e;

  localparam int DEFAULT_SEL_WIDTH = 2;

  function automatic int mask_width(input int sel_width);
    return 1 << sel_width;
  endfunction

endpackage

// File: rtl/bit_demux_1xn.sv
// Combinational 1-to-2**SEL_WIDTH one-hot demux of an enable, built as a
// binary tree of 1x2 demux cells (same shape as the selector mux tree).
//   en      : enable routed to the selected leaf
//   sel     : leaf index, MSB steers the root cell
//   onehot  : per-position write enables (all zero when en=0)
module bit_demux_1xn #(
  parameter int SEL_WIDTH = 2
) (
  input  logic                       en,
  input  logic [SEL_WIDTH-1:0]       sel,
  output logic [(1<<SEL_WIDTH)-1:0]  onehot
);

  localparam int N = 1 << SEL_WIDTH;

  // Heap-ordered tree: node k feeds children 2k+1 / 2k+2; leaves start at N-1.
  logic [2*N-2:0] node;

  assign node[0] = en;

  for (genvar l = 0; l < SEL_WIDTH; l++) begin : g_level
    for (genvar n = 0; n < (1 << l); n++) begin : g_cell
      localparam int P  = (1 << l) - 1 + n;
      localparam int C0 = (1 << (l + 1)) - 1 + 2 * n;
      assign node[C0]     = node[P] & ~sel[SEL_WIDTH-1-l];
      assign node[C0 + 1] = node[P] &  sel[SEL_WIDTH-1-l];
    end
  end

  assign onehot = node[2*N-2 : N-1];

endmodule

// File: rtl/bit_demux_collector.sv
// Bit demux collector: deposits tagged single bits into a DATA_WIDTH word and
// hands the word out on a valid/ready port once every position was written.
//   clk, rst        : clock, synchronous active-high reset
//   i_bit, i_sel    : data bit and its target position
//   i_valid/i_ready : input handshake
//   o_data          : assembled word (registered)
//   o_valid/o_ready : output handshake
//   o_err           : sticky duplicate-write flag, only when
//                     BIT_DEMUX_DUP_ERR_EN is defined
//
// state   | meaning
// --------+---------------------------------------------------------------
// COLLECT | accepting bits; leaves when the fill mask becomes all-ones
// FULL    | word complete, o_valid=1, inputs stalled until o_ready
module bit_demux_collector
  import bit_demux_collector_pkg::*;
#(
  parameter int SEL_WIDTH  = DEFAULT_SEL_WIDTH,
  parameter int DATA_WIDTH = 1 << SEL_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_bit,
  input  logic [SEL_WIDTH-1:0]  i_sel,
  input  logic                  i_valid,
  output logic                  i_ready,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_valid,
  input  logic                  o_ready
`ifdef BIT_DEMUX_DUP_ERR_EN
  ,
  output logic                  o_err
`endif
);

  localparam int                  MASK_W   = mask_width(SEL_WIDTH);
  localparam logic [MASK_W-1:0]   ALL_ONES = {MASK_W{1'b1}};

  state_e                 state, next_state;
  logic [MASK_W-1:0]      mask;
  logic [DATA_WIDTH-1:0]  data_reg;
  logic [MASK_W-1:0]      wr_onehot;
  logic [MASK_W-1:0]      mask_set;
  logic                   wr_en;

  assign wr_en    = i_valid & i_ready;
  assign mask_set = mask | wr_onehot;

  bit_demux_1xn #(
    .SEL_WIDTH (SEL_WIDTH)
  ) u_demux (
    .en     (wr_en),
    .sel    (i_sel),
    .onehot (wr_onehot)
  );

  always_comb begin
    next_state = state;
    i_ready    = 1'b0;
    o_valid    = 1'b0;
    case (state)
      COLLECT: begin
        i_ready = 1'b1;
        if (wr_en && (mask_set == ALL_ONES)) next_state = FULL;
      end
      FULL: begin
        o_valid = 1'b1;
        if (o_ready) next_state = COLLECT;
      end
      default: next_state = COLLECT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= COLLECT;
      mask     <= '0;
      data_reg <= '0;
    end else begin
      state <= next_state;
      if (state == FULL && o_ready) begin
        mask     <= '0;
        data_reg <= '0;
      end else begin
        // wr_onehot is all-zero in FULL, so this holds the word while stalled.
        mask     <= mask_set;
        data_reg <= (data_reg & ~wr_onehot) | (wr_onehot & {DATA_WIDTH{i_bit}});
      end
    end
  end

`ifdef BIT_DEMUX_DUP_ERR_EN
  always_ff @(posedge clk) begin
    if (rst)                   o_err <= 1'b0;
    else if (|(wr_onehot & mask)) o_err <= 1'b1;
  end
`endif

  assign o_data = data_reg;

endmodule

// File: tb/tb_bit_demux_collector.sv
module tb_bit_demux_collector;

  localparam int SW = 2;
  localparam int DW = 1 << SW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          i_bit = 1'b0;
  logic [SW-1:0] i_sel = '0;
  logic          i_valid = 1'b0;
  logic          i_ready;
  logic [DW-1:0] o_data;
  logic          o_valid;
  logic          o_ready = 1'b0;

  logic          i_bit8 = 1'b0;
  logic [2:0]    i_sel8 = '0;
  logic          i_valid8 = 1'b0;
  logic          i_ready8;
  logic [7:0]    o_data8;
  logic          o_valid8;
  logic          o_ready8 = 1'b0;

`ifdef BIT_DEMUX_DUP_ERR_EN
  logic o_err, o_err8;
`endif

  always #5 clk = ~clk;

  bit_demux_collector #(.SEL_WIDTH(SW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst), .i_bit(i_bit), .i_sel(i_sel), .i_valid(i_valid),
    .i_ready(i_ready), .o_data(o_data), .o_valid(o_valid), .o_ready(o_ready)
`ifdef BIT_DEMUX_DUP_ERR_EN
    , .o_err(o_err)
`endif
  );

  bit_demux_collector #(.SEL_WIDTH(3), .DATA_WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .i_bit(i_bit8), .i_sel(i_sel8), .i_valid(i_valid8),
    .i_ready(i_ready8), .o_data(o_data8), .o_valid(o_valid8), .o_ready(o_ready8)
`ifdef BIT_DEMUX_DUP_ERR_EN
    , .o_err(o_err8)
`endif
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: which positions hold a bit for the word under
  // construction, whether a finished word is waiting, and the scoreboard.
  bit            m_bits[DW];
  bit            m_wr[DW];
  bit            m_full;
  bit            m_err;
  logic [DW-1:0] sb_q[$];

  function automatic void model_clear();
    for (int i = 0; i < DW; i++) begin
      m_bits[i] = 1'b0;
      m_wr[i]   = 1'b0;
    end
  endfunction

  // Scoreboard monitor: inputs change just after posedge, so at negedge
  // o_ready is the value the next edge will see.
  always @(negedge clk) begin
    if (!rst && o_valid) begin
      if (sb_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL sb_unexpected_word: got %0h expected no word at %0t", o_data, $time);
      end else begin
        chk("sb_o_data", 32'(o_data), 32'(sb_q[0]));
        if (o_ready) void'(sb_q.pop_front());
      end
    end
  end

  task automatic do_reset();
    rst     = 1'b1;
    i_valid = 1'b0;
    o_ready = 1'b0;
    @(posedge clk);
    model_clear();
    m_full = 1'b0;
    m_err  = 1'b0;
    sb_q.delete();
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_o_valid", 32'(o_valid), 32'd0);
    chk("rst_o_data",  32'(o_data),  32'd0);
    chk("rst_i_ready", 32'(i_ready), 32'd1);
`ifdef BIT_DEMUX_DUP_ERR_EN
    chk("rst_o_err",   32'(o_err),   32'd0);
`endif
    @(posedge clk);
    #1;
  endtask

  // One clock: drive, check handshake outputs at negedge, advance model at posedge.
  task automatic step(input bit v, input int s, input bit b, input bit ordy);
    logic [DW-1:0] w;
    bit            all;
    i_valid = v;
    i_sel   = SW'(s);
    i_bit   = b;
    o_ready = ordy;
    @(negedge clk);
    chk("i_ready", 32'(i_ready), 32'(!m_full));
    chk("o_valid", 32'(o_valid), 32'(m_full));
`ifdef BIT_DEMUX_DUP_ERR_EN
    chk("o_err", 32'(o_err), 32'(m_err));
`endif
    @(posedge clk);
    if (m_full) begin
      if (ordy) m_full = 1'b0;
    end else if (v) begin
      if (m_wr[s]) m_err = 1'b1;
      m_bits[s] = b;
      m_wr[s]   = 1'b1;
      all = 1'b1;
      for (int i = 0; i < DW; i++) begin
        all  = all & m_wr[i];
        w[i] = m_bits[i];
      end
      if (all) begin
        sb_q.push_back(w);
        m_full = 1'b1;
        model_clear();
      end
    end
    #1;
  endtask

  int           pos[8];
  logic [7:0]   pat8;

  initial begin
    do_reset();

    // in-order word, immediate consume
    step(1, 0, 1, 1); step(1, 1, 0, 1); step(1, 2, 1, 1); step(1, 3, 1, 1);
    step(0, 0, 0, 1); step(0, 0, 0, 1);

    // out-of-order
    step(1, 3, 1, 1); step(1, 1, 1, 1); step(1, 0, 0, 1); step(1, 2, 0, 1);
    step(0, 0, 0, 1); step(0, 0, 0, 1);

    // duplicate position
    step(1, 2, 1, 1); step(1, 2, 0, 1); step(1, 0, 1, 1); step(1, 1, 1, 1);
    step(1, 3, 1, 1); step(0, 0, 0, 1); step(0, 0, 0, 1);

    do_reset();

    // backpressure while the source keeps offering bits
    step(1, 1, 1, 0); step(1, 0, 1, 0); step(1, 3, 0, 0); step(1, 2, 1, 0);
    for (int k = 0; k < 5; k++) step(1, k % DW, 1, 0);
    step(1, 0, 0, 1);
    step(1, 0, 0, 0); step(1, 1, 1, 0); step(1, 2, 0, 0); step(1, 3, 1, 1);
    step(0, 0, 0, 1); step(0, 0, 0, 1);

    // reset mid-word
    step(1, 0, 1, 1); step(1, 1, 1, 1);
    do_reset();
    step(1, 2, 1, 1); step(1, 3, 0, 1); step(0, 0, 0, 1);
    step(1, 0, 0, 1); step(1, 1, 1, 1); step(0, 0, 0, 1); step(0, 0, 0, 1);

    // randomized traffic with occasional reset
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 99) == 0) do_reset();
      else step($urandom_range(0, 3) != 0, $urandom_range(0, DW - 1),
                1'($urandom), $urandom_range(0, 2) != 0);
    end
    for (int k = 0; k < 3; k++) step(0, 0, 0, 1);
    chk("sb_drained", 32'(sb_q.size()), 32'd0);

    // 8-wide instance: pattern A5 written in shuffled order
    pat8 = 8'hA5;
    for (int k = 0; k < 8; k++) pos[k] = k;
    for (int k = 7; k > 0; k--) begin
      int j, t;
      j = $urandom_range(0, k);
      t = pos[k]; pos[k] = pos[j]; pos[j] = t;
    end
    for (int k = 0; k < 8; k++) begin
      i_valid8 = 1'b1;
      i_sel8   = 3'(pos[k]);
      i_bit8   = pat8[pos[k]];
      @(negedge clk);
      chk("w8_i_ready", 32'(i_ready8), 32'd1);
      chk("w8_o_valid_early", 32'(o_valid8), 32'd0);
      @(posedge clk);
      #1;
    end
    i_valid8 = 1'b0;
    o_ready8 = 1'b1;
    @(negedge clk);
    chk("w8_o_valid", 32'(o_valid8), 32'd1);
    chk("w8_o_data",  32'(o_data8),  32'h0000_00A5);
    chk("w8_i_ready_full", 32'(i_ready8), 32'd0);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("w8_o_valid_after", 32'(o_valid8), 32'd0);
    chk("w8_i_ready_after", 32'(i_ready8), 32'd1);
    chk("w8_o_data_cleared", 32'(o_data8), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
